// File: rtl/text_pkg.sv
// Shared geometry, cell format, FSM states and ASCII constants for the
// character-cell text buffer.
package text_pkg;

   localparam int unsigned COLS   = 41;
   localparam int unsigned ROWS   = 8;
   localparam int unsigned CELLS  = 328;
   localparam int unsigned COL_W  = 6;
   localparam int unsigned ROW_W  = 3;
   localparam int unsigned IDX_W  = 9;
   localparam int unsigned CELL_W = 32;
   localparam int unsigned RGB_W  = 24;
   localparam int unsigned CHAR_W = 8;

   localparam logic [CELL_W-1:0] BLANK_CELL = 32'hFFFFFF20;

   localparam logic [CHAR_W-1:0] ASCII_LF    = 8'h0A;
   localparam logic [CHAR_W-1:0] ASCII_CR    = 8'h0D;
   localparam logic [CHAR_W-1:0] ASCII_BS    = 8'h08;
   localparam logic [CHAR_W-1:0] ASCII_FIRST = 8'h20;
   localparam logic [CHAR_W-1:0] ASCII_LAST  = 8'h7E;

   localparam logic [COL_W-1:0] LAST_COL  = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(ROWS - 1);
   localparam logic [IDX_W-1:0] LAST_CELL = IDX_W'(CELLS - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CLEAR  = 2'd1,
      SCROLL = 2'd2
   } state_t;

   typedef struct packed {
      logic [RGB_W-1:0]  rgb;
      logic [CHAR_W-1:0] code;
   } cell_t;

   // Linear cell index of (row, col); the largest value, 327, fits in IDX_W bits.
   function automatic logic [IDX_W-1:0] cell_index(input logic [ROW_W-1:0] row,
                                                   input logic [COL_W-1:0] col);
      return IDX_W'(row) * IDX_W'(COLS) + IDX_W'(col);
   endfunction

   function automatic logic is_printable(input logic [CHAR_W-1:0] code);
      return (code >= ASCII_FIRST) && (code <= ASCII_LAST);
   endfunction

endpackage

// File: rtl/text_cursor.sv
// Cursor movement for one accepted character: wrap, newline, carriage
// return, backspace and bottom-row overflow detection.
module text_cursor
   import text_pkg::*;
(
   input  logic [COL_W-1:0]  col,
   input  logic [ROW_W-1:0]  row,
   input  logic [CHAR_W-1:0] code,
   output logic [COL_W-1:0]  next_col,
   output logic [ROW_W-1:0]  next_row,
   output logic              overflow
);

   always_comb begin
      next_col = col;
      next_row = row;
      overflow = 1'b0;
      if (is_printable(code)) begin
         if (col == LAST_COL) begin
            next_col = '0;
            if (row == LAST_ROW) begin
               overflow = 1'b1;
            end else begin
               next_row = row + ROW_W'(1);
            end
         end else begin
            next_col = col + COL_W'(1);
         end
      end else if (code == ASCII_LF) begin
         next_col = '0;
         if (row == LAST_ROW) begin
            overflow = 1'b1;
         end else begin
            next_row = row + ROW_W'(1);
         end
      end else if (code == ASCII_CR) begin
         next_col = '0;
      end else if (code == ASCII_BS) begin
         // Backspace at column 0 climbs to the end of the previous row.
         if (col != '0) begin
            next_col = col - COL_W'(1);
         end else if (row != '0) begin
            next_col = LAST_COL;
            next_row = row - ROW_W'(1);
         end
      end
   end

endmodule

// File: rtl/text_buffer_writer.sv
// Character-stream writer into a 41x8 text cell array, with whole-screen
// clear and one-row scroll on bottom-row overflow.
module text_buffer_writer
   import text_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              char_valid,
   input  logic [CHAR_W-1:0] char_data,
   input  logic [RGB_W-1:0]  fg_color,
   output logic              char_ready,
   input  logic              clear_req,
   output logic [CELL_W-1:0] ram [CELLS-1:0],
   output logic [COL_W-1:0]  cursor_col,
   output logic [ROW_W-1:0]  cursor_row,
   output logic              busy
);

   state_t            state, state_n;
   logic [IDX_W-1:0]  clr_cnt, clr_cnt_n;
   logic [ROW_W-1:0]  scr_cnt, scr_cnt_n;
   logic [COL_W-1:0]  col_n;
   logic [ROW_W-1:0]  row_n;

   logic              wr_en;
   logic [IDX_W-1:0]  wr_idx;
   logic [CELL_W-1:0] wr_data;
   logic              scr_copy;
   logic              scr_blank;

   logic [COL_W-1:0]  nxt_col;
   logic [ROW_W-1:0]  nxt_row;
   logic              ovf;
   logic              accept;

   text_cursor u_cursor (
      .col      (cursor_col),
      .row      (cursor_row),
      .code     (char_data),
      .next_col (nxt_col),
      .next_row (nxt_row),
      .overflow (ovf)
   );

   assign char_ready = (state == IDLE) && !clear_req && !rst;
   assign busy       = (state != IDLE);
   assign accept     = char_valid && char_ready;

   // State, counters and cursor.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         clr_cnt    <= '0;
         scr_cnt    <= '0;
         cursor_col <= '0;
         cursor_row <= '0;
      end else begin
         state      <= state_n;
         clr_cnt    <= clr_cnt_n;
         scr_cnt    <= scr_cnt_n;
         cursor_col <= col_n;
         cursor_row <= row_n;
      end
   end

   // Next state, cursor and cell-write decode.
   always_comb begin
      state_n   = state;
      clr_cnt_n = clr_cnt;
      scr_cnt_n = scr_cnt;
      col_n     = cursor_col;
      row_n     = cursor_row;
      wr_en     = 1'b0;
      wr_idx    = '0;
      wr_data   = BLANK_CELL;
      scr_copy  = 1'b0;
      scr_blank = 1'b0;

      unique case (state)
         IDLE: begin
            if (clear_req) begin
               state_n   = CLEAR;
               clr_cnt_n = '0;
            end else if (accept) begin
               col_n = nxt_col;
               row_n = nxt_row;
               if (is_printable(char_data)) begin
                  wr_en   = 1'b1;
                  wr_idx  = cell_index(cursor_row, cursor_col);
                  wr_data = cell_t'{rgb: fg_color, code: char_data};
               end else if ((char_data == ASCII_BS) &&
                            ((cursor_col != '0) || (cursor_row != '0))) begin
                  wr_en   = 1'b1;
                  wr_idx  = cell_index(nxt_row, nxt_col);
                  wr_data = BLANK_CELL;
               end
               if (ovf) begin
                  state_n   = SCROLL;
                  scr_cnt_n = '0;
               end
            end
         end

         CLEAR: begin
            wr_en   = 1'b1;
            wr_idx  = clr_cnt;
            wr_data = BLANK_CELL;
            if (clr_cnt == LAST_CELL) begin
               state_n   = IDLE;
               clr_cnt_n = '0;
               col_n     = '0;
               row_n     = '0;
            end else begin
               clr_cnt_n = clr_cnt + IDX_W'(1);
            end
         end

         SCROLL: begin
            // Rows 0..6 pull up from the row below, then row 7 is blanked.
            if (scr_cnt == LAST_ROW) begin
               scr_blank = 1'b1;
               scr_cnt_n = '0;
               state_n   = IDLE;
            end else begin
               scr_copy  = 1'b1;
               scr_cnt_n = scr_cnt + ROW_W'(1);
            end
         end

         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // Cell array: reset blanks every cell immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < CELLS; i++) begin
            ram[i] <= BLANK_CELL;
         end
      end else begin
         if (wr_en) begin
            ram[wr_idx] <= wr_data;
         end
         if (scr_copy) begin
            for (int unsigned c = 0; c < COLS; c++) begin
               ram[cell_index(scr_cnt, COL_W'(c))] <=
                  ram[cell_index(scr_cnt + ROW_W'(1), COL_W'(c))];
            end
         end
         if (scr_blank) begin
            for (int unsigned c = 0; c < COLS; c++) begin
               ram[cell_index(LAST_ROW, COL_W'(c))] <= BLANK_CELL;
            end
         end
      end
   end

endmodule

// File: tb/tb_text_buffer_writer.sv
// Self-checking bench for text_buffer_writer: table vectors, corner-case
// sequences and random traffic against a linear-position screen model.
module tb_text_buffer_writer;

   localparam logic [31:0] BLANK = 32'hFFFFFF20;
   localparam int NCELL = 328;
   localparam int NCOL  = 41;

   logic        clk;
   logic        rst;
   logic        char_valid;
   logic [7:0]  char_data;
   logic [23:0] fg_color;
   logic        char_ready;
   logic        clear_req;
   logic [31:0] ram [327:0];
   logic [5:0]  cursor_col;
   logic [2:0]  cursor_row;
   logic        busy;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_ram [NCELL];
   int          pos;

   typedef struct {
      logic [7:0]  code;
      logic [23:0] fg;
      int          ecol;
      int          erow;
      int          idx;
      logic [31:0] ecell;
   } vec_t;

   vec_t vt [14];

   text_buffer_writer dut (
      .clk        (clk),
      .rst        (rst),
      .char_valid (char_valid),
      .char_data  (char_data),
      .fg_color   (fg_color),
      .char_ready (char_ready),
      .clear_req  (clear_req),
      .ram        (ram),
      .cursor_col (cursor_col),
      .cursor_row (cursor_row),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, got, exp);
      end
   endtask

   task automatic chk_cursor(input string name, input int p);
      chk(name, 32'({cursor_row, cursor_col}), 32'({3'(p / NCOL), 6'(p % NCOL)}));
   endtask

   task automatic chk_ram(input string name);
      int bad = 0;
      int first = -1;
      for (int i = 0; i < NCELL; i++) begin
         if (ram[i] !== m_ram[i]) begin
            bad++;
            if (first < 0) first = i;
         end
      end
      if (bad != 0)
         $display("  first differing cell %0d dut %h model %h", first, ram[first], m_ram[first]);
      chk(name, 32'(bad), 32'd0);
   endtask

   task automatic model_blank();
      for (int i = 0; i < NCELL; i++) m_ram[i] = BLANK;
      pos = 0;
   endtask

   task automatic model_scroll();
      for (int i = 0; i < NCELL - NCOL; i++) m_ram[i] = m_ram[i + NCOL];
      for (int i = NCELL - NCOL; i < NCELL; i++) m_ram[i] = BLANK;
      pos = NCELL - NCOL;
   endtask

   // Screen as a linear sequence of cells; the cursor is one position.
   task automatic model_char(input logic [7:0] code, input logic [23:0] fg);
      if (code >= 8'h20 && code <= 8'h7E) begin
         m_ram[pos] = {fg, code};
         pos++;
         if (pos == NCELL) model_scroll();
      end else if (code == 8'h0A) begin
         pos = (pos / NCOL + 1) * NCOL;
         if (pos >= NCELL) model_scroll();
      end else if (code == 8'h0D) begin
         pos = pos - pos % NCOL;
      end else if (code == 8'h08) begin
         if (pos > 0) begin
            pos--;
            m_ram[pos] = BLANK;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      char_valid = 1'b0;
      clear_req = 1'b0;
      model_blank();
      #1;
      chk("rst_ready", 32'(char_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk_cursor("rst_cursor", 0);
      chk_ram("rst_ram");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("ready_after_reset", 32'(char_ready), 32'd1);
   endtask

   task automatic send_raw(input logic [7:0] code, input logic [23:0] fg);
      int n = 0;
      @(negedge clk);
      char_valid = 1'b1;
      char_data = code;
      fg_color = fg;
      while (!char_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (!char_ready) begin
         chk("accept_timeout", 32'(char_ready), 32'd1);
         char_valid = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      char_valid = 1'b0;
      model_char(code, fg);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (busy) chk("idle_timeout", 32'(busy), 32'd0);
   endtask

   task automatic send(input logic [7:0] code, input logic [23:0] fg);
      send_raw(code, fg);
      wait_idle();
   endtask

   task automatic do_clear(input logic with_char);
      int n = 0;
      @(negedge clk);
      clear_req = 1'b1;
      char_valid = with_char;
      char_data = 8'h58;
      fg_color = 24'h111111;
      @(negedge clk);
      clear_req = 1'b0;
      char_valid = 1'b0;
      chk_cursor("clear_no_accept_cursor", pos);
      chk_ram("clear_no_accept_ram");
      while (busy && n < 1000) begin
         n++;
         @(negedge clk);
      end
      chk("clear_busy_cycles", 32'(n), 32'd328);
      model_blank();
      chk_cursor("clear_cursor", pos);
      chk_ram("clear_ram");
   endtask

   initial begin
      rst = 1'b1;
      char_valid = 1'b0;
      char_data = 8'h00;
      fg_color = 24'h0;
      clear_req = 1'b0;
      model_blank();

      vt[0]  = '{8'h41, 24'h00FF00, 1, 0, 0,  32'h00FF0041};
      vt[1]  = '{8'h62, 24'h123456, 2, 0, 1,  32'h12345662};
      vt[2]  = '{8'h0D, 24'h000000, 0, 0, 1,  32'h12345662};
      vt[3]  = '{8'h0A, 24'h000000, 0, 1, 0,  32'h00FF0041};
      vt[4]  = '{8'h01, 24'h000000, 0, 1, 41, 32'hFFFFFF20};
      vt[5]  = '{8'h5A, 24'hABCDEF, 1, 1, 41, 32'hABCDEF5A};
      vt[6]  = '{8'h08, 24'h000000, 0, 1, 41, 32'hFFFFFF20};
      vt[7]  = '{8'h08, 24'h000000, 40, 0, 40, 32'hFFFFFF20};
      vt[8]  = '{8'h7E, 24'h000001, 0, 1, 40, 32'h0000017E};
      vt[9]  = '{8'h7F, 24'h000000, 0, 1, 40, 32'h0000017E};
      vt[10] = '{8'h08, 24'h000000, 40, 0, 40, 32'hFFFFFF20};
      vt[11] = '{8'h0A, 24'h000000, 0, 1, 40, 32'hFFFFFF20};
      vt[12] = '{8'h20, 24'hFF0000, 1, 1, 41, 32'hFF000020};
      vt[13] = '{8'h1F, 24'h000000, 1, 1, 41, 32'hFF000020};

      do_reset();
      for (int i = 0; i < 14; i++) begin
         send(vt[i].code, vt[i].fg);
         chk($sformatf("vec%0d_cursor", i), 32'({cursor_row, cursor_col}),
             32'({3'(vt[i].erow), 6'(vt[i].ecol)}));
         chk($sformatf("vec%0d_cell", i), ram[vt[i].idx], vt[i].ecell);
      end

      // Backspace at the origin does nothing.
      do_reset();
      send(8'h08, 24'h0);
      chk_cursor("bs_origin_cursor", 0);
      chk_ram("bs_origin_ram");

      // A full row of 'B' wraps to the next row.
      do_reset();
      for (int i = 0; i < 41; i++) send(8'h42, 24'h0000FF);
      chk("row_fill_first", ram[0], 32'h0000FF42);
      chk("row_fill_last", ram[40], 32'h0000FF42);
      chk_cursor("row_fill_cursor", 41);
      send(8'h42, 24'h0000FF);
      chk("row_wrap_cell", ram[41], 32'h0000FF42);
      chk_ram("row_fill_ram");

      // Fill to the last cell, then overflow into a scroll.
      do_reset();
      for (int i = 0; i < 327; i++) send(8'(32 + i % 95), 24'(i * 7919));
      chk_cursor("fill_cursor", 327);
      begin
         logic [31:0] old41;
         int n = 0;
         int rdy = 0;
         int blanks = 0;
         old41 = m_ram[41];
         send_raw(8'h41, 24'hABCDEF);
         while (busy && n < 50) begin
            n++;
            if (char_ready) rdy++;
            @(negedge clk);
         end
         chk("scroll_busy_cycles", 32'(n), 32'd8);
         chk("scroll_ready_low", 32'(rdy), 32'd0);
         chk("scroll_row0", ram[0], old41);
         for (int c = 287; c < 328; c++) if (ram[c] === BLANK) blanks++;
         chk("scroll_row7_blank", 32'(blanks), 32'd41);
         chk_cursor("scroll_cursor", 287);
         chk_ram("scroll_ram");
      end

      // Clear requested together with a character.
      do_clear(1'b1);

      // Reset in the middle of a clear takes effect without a clock edge.
      do_reset();
      for (int i = 0; i < 200; i++) send(8'(33 + i % 90), 24'(i));
      @(negedge clk);
      clear_req = 1'b1;
      @(negedge clk);
      clear_req = 1'b0;
      repeat (100) @(negedge clk);
      chk("midclear_busy", 32'(busy), 32'd1);
      #1;
      rst = 1'b1;
      #1;
      model_blank();
      chk_ram("midclear_rst_ram");
      chk_cursor("midclear_rst_cursor", 0);
      chk("midclear_rst_busy", 32'(busy), 32'd0);
      chk("midclear_rst_ready", 32'(char_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Random traffic against the model.
      do_reset();
      for (int it = 0; it < 400; it++) begin
         int r;
         logic [7:0] code;
         r = $urandom_range(0, 99);
         if (r < 2) begin
            do_clear(1'($urandom_range(0, 1)));
         end else begin
            if (r < 12)      code = 8'h0A;
            else if (r < 17) code = 8'h0D;
            else if (r < 25) code = 8'h08;
            else if (r < 29) code = 8'($urandom_range(128, 255));
            else             code = 8'($urandom_range(32, 126));
            send(code, 24'($urandom));
            chk_cursor($sformatf("rand%0d_cursor", it), pos);
            chk_ram($sformatf("rand%0d_ram", it));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/text_buffer_writer.md
TEXT_BUFFER_WRITER -- requirements
Module: text_buffer_writer

Interface
REQ-001 Parameters: none; all geometry comes from the shared package.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 char_valid  input  1  a character is offered on char_data.
REQ-005 char_data  input  8  ASCII code offered.
REQ-006 fg_color  input  24  RGB foreground colour stored with each written character.
REQ-007 char_ready  output  1  the block accepts char_data this cycle.
REQ-008 clear_req  input  1  request to blank the whole screen.
REQ-009 ram  output  32 x 328 (unpacked, index 327:0)  display cell array feeding the VGA text renderer.
REQ-010 cursor_col  output  6  current column, 0..40.
REQ-011 cursor_row  output  3  current row, 0..7.
REQ-012 busy  output  1  high in CLEAR or SCROLL.

Function
REQ-013 Geometry: 41 columns x 8 rows = 328 cells; cell index = row*41 + col.
REQ-014 Cell format: [7:0] ASCII code, [31:8] RGB colour; BLANK_CELL = 32'hFFFFFF20.
REQ-015 FSM states: IDLE, CLEAR, SCROLL; reset state is IDLE.
REQ-016 char_ready = 1 only in IDLE with clear_req low and rst low.
REQ-017 Handshake: a character is accepted on an edge where char_valid and char_ready are both 1.
REQ-018 Holding: char_valid and char_data are held by the source until accepted.
REQ-019 Simultaneous events: clear_req high in IDLE enters CLEAR on the next edge; no character is accepted that cycle.
REQ-020 Printable codes 0x20..0x7E:
  - on the accepting edge, write {fg_color, code} to the cursor cell;
  - advance the column;
  - column 40 wraps to 0 and the row increments.
REQ-021 0x0A newline: column 0, row+1; no cell written.
REQ-022 0x0D carriage return: column 0 only.
REQ-023 0x08 backspace:
  - col>0: col-1, then write BLANK_CELL at the new position;
  - col=0 and row>0: move to (40, row-1), then blank that cell;
  - at (0,0): no-op.
REQ-024 Other codes: accepted and ignored; no cell or cursor change.
REQ-025 Bottom-row overflow: when a wrap or newline would move past row 7, go to SCROLL and leave the cursor at row 7, col 0.
REQ-026 SCROLL:
  - one row copy per cycle, row r <= row r+1 for r = 0..6 (7 cycles);
  - row 7 <= BLANK_CELL on the 8th cycle;
  - then return to IDLE. Total 8 cycles, char_ready low throughout.
REQ-027 CLEAR:
  - write BLANK_CELL to one cell per cycle, index 0..327 (328 cycles);
  - then cursor (0,0) and return to IDLE;
  - clear_req is ignored while in CLEAR.
REQ-028 Cell-write latency: a written cell is visible on ram on the accepting edge, i.e. readable in the following cycle.
REQ-029 Cursor latency: the cursor updates on the same edge as the cell write.
REQ-030 ram holds its value in all cycles with no write.

Reset
REQ-031 While rst=1, independent of clk:
  - every ram cell = BLANK_CELL;
  - cursor = (0,0);
  - state = IDLE;
  - busy = 0, char_ready = 0, all internal counters 0.
REQ-032 Reset mid-CLEAR or mid-SCROLL aborts the operation immediately and yields the REQ-031 state.
REQ-033 After reset release: char_ready = 1 in the first cycle in which clear_req is low.

Structure
REQ-034 Shared package text_pkg SHALL hold:
  - COLS=41, ROWS=8, CELLS=328;
  - BLANK_CELL;
  - the state enum {IDLE, CLEAR, SCROLL};
  - the ASCII constants for LF, CR and BS.
REQ-035 Sub-module text_cursor SHALL own row/col update, wrap and overflow detection; its outputs are next_col, next_row, overflow.
REQ-036 The top module owns the FSM, the CLEAR counter, the SCROLL counter and the ram array.

Verification
REQ-037 Write 'A' (0x41) with fg_color 24'h00FF00 after reset -> ram[0] = 32'h00FF0041 next cycle, cursor (1,0).
REQ-038 Send 41 x 'B' -> ram[0..40] = {fg,0x42}, cursor (0,1); a 42nd 'B' lands in ram[41].
REQ-039 Fill to (40,7), then send one more char -> busy high 8 cycles; old row1 appears in row0; row7 all 32'hFFFFFF20; cursor (0,7).
REQ-040 Pulse clear_req with char_valid high the same cycle -> char not accepted; busy high 328 cycles; all cells BLANK_CELL; cursor (0,0).
REQ-041 Backspace at (0,1) -> cursor (40,0) and ram[40] = BLANK_CELL; backspace at (0,0) -> no change.
REQ-042 Assert rst 100 cycles into CLEAR -> all cells BLANK_CELL at once; cursor (0,0); busy=0.
